// File: rtl/remapper_pkg.sv
// Shared types and helpers for the stream-to-kernel packer.
package remapper_pkg;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic int beats(input int kernel, input int ppb);
    return kernel / ppb;
  endfunction

endpackage

// File: rtl/s_axis_kernel_packer_shift.sv
// Fill buffer: shifts PIXELS_PER_BEAT pixels toward index 0 per accepted beat.
module kernel_shift_buffer #(
  parameter int DATA_WIDTH      = 8,
  parameter int PIXELS_PER_BEAT = 1,
  parameter int KERNEL_SIZE     = 64
) (
  input  logic                                      clk_i,
  input  logic                                      clr_i,
  input  logic                                      shift_i,
  input  logic [PIXELS_PER_BEAT*DATA_WIDTH-1:0]     pix_i,
  output logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0]    buf_o,
  output logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0]    nxt_o
);

  logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (shift_i) begin
      for (int i = 0; i < KERNEL_SIZE - PIXELS_PER_BEAT; i++)
        buf_d[i] = buf_q[i+PIXELS_PER_BEAT];
      // Lane 0 is the earliest pixel of the beat, so it lands lowest.
      for (int l = 0; l < PIXELS_PER_BEAT; l++)
        buf_d[KERNEL_SIZE-PIXELS_PER_BEAT+l] = pix_i[l*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) buf_q <= '0;
    else       buf_q <= buf_d;
  end

  assign buf_o = buf_q;
  assign nxt_o = buf_d;

endmodule

// File: rtl/s_axis_kernel_packer.sv
// Packs an AXI4-Stream pixel stream into whole kernels behind a one-kernel
// output register, with backpressure and tuser-driven frame resync.
module s_axis_kernel_packer
  import remapper_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int PIXELS_PER_BEAT = 1,
  parameter int KERNEL_SIZE     = 64
) (
  input  logic                                   i_clk,
  input  logic                                   i_aresetn,
  input  logic                                   i_odd_kernel,
  input  logic [PIXELS_PER_BEAT*DATA_WIDTH-1:0]  i_axis_tdata,
  input  logic                                   i_axis_tvalid,
  input  logic                                   i_axis_tuser,
  output logic                                   o_axis_tready,
  output logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] o_image_kernel,
  output logic                                   o_kernel_valid,
  input  logic                                   i_kernel_ready,
  output logic                                   o_kernel_is_odd,
  output logic                                   o_kernel_sof,
  output logic                                   o_resync
);

  localparam int BEATS = beats(KERNEL_SIZE, PIXELS_PER_BEAT);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if (KERNEL_SIZE % PIXELS_PER_BEAT != 0) begin : g_bad_ppb
    $error("PIXELS_PER_BEAT must divide KERNEL_SIZE");
  end

  state_e                                 state_q;
  logic [CNT_W-1:0]                       cnt_q;
  logic                                   pend_odd_q, pend_sof_q;
  logic                                   tready_q, kvalid_q, odd_q, sof_q, resync_q;
  logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] kernel_q;
  logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] fill_buf, fill_nxt;

  logic acc, out_free, first, last, resync_evt, done;
  logic tag_odd, tag_sof;

  assign acc        = i_axis_tvalid & tready_q;
  assign out_free   = ~kvalid_q | i_kernel_ready;
  assign first      = (cnt_q == '0);
  assign last       = (cnt_q == LAST_CNT);
  assign resync_evt = acc & i_axis_tuser & ~first;
  assign done       = acc & last & ~resync_evt;
  // A single-beat kernel has no earlier beat to have latched its tags.
  assign tag_odd    = first ? i_odd_kernel : pend_odd_q;
  assign tag_sof    = first ? i_axis_tuser : pend_sof_q;

  kernel_shift_buffer #(
    .DATA_WIDTH      (DATA_WIDTH),
    .PIXELS_PER_BEAT (PIXELS_PER_BEAT),
    .KERNEL_SIZE     (KERNEL_SIZE)
  ) u_fill (
    .clk_i   (i_clk),
    .clr_i   (~i_aresetn),
    .shift_i (acc),
    .pix_i   (i_axis_tdata),
    .buf_o   (fill_buf),
    .nxt_o   (fill_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      pend_odd_q <= 1'b0;
      pend_sof_q <= 1'b0;
      tready_q   <= 1'b0;
      kvalid_q   <= 1'b0;
      kernel_q   <= '0;
      odd_q      <= 1'b0;
      sof_q      <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      resync_q <= resync_evt;

      if (acc) begin
        if (resync_evt)  cnt_q <= CNT_W'(1);
        else if (last)   cnt_q <= '0;
        else             cnt_q <= cnt_q + CNT_W'(1);
        if (first || resync_evt) begin
          pend_odd_q <= i_odd_kernel;
          pend_sof_q <= i_axis_tuser;
        end
      end

      if (kvalid_q && i_kernel_ready) kvalid_q <= 1'b0;

      case (state_q)
        FILL: begin
          tready_q <= 1'b1;
          if (done) begin
            if (out_free) begin
              kernel_q <= fill_nxt;
              odd_q    <= tag_odd;
              sof_q    <= tag_sof;
              kvalid_q <= 1'b1;
            end else begin
              state_q  <= WAIT;
              tready_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (out_free) begin
            kernel_q <= fill_buf;
            odd_q    <= pend_odd_q;
            sof_q    <= pend_sof_q;
            kvalid_q <= 1'b1;
            state_q  <= FILL;
            tready_q <= 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign o_axis_tready   = tready_q;
  assign o_image_kernel  = kernel_q;
  assign o_kernel_valid  = kvalid_q;
  assign o_kernel_is_odd = odd_q;
  assign o_kernel_sof    = sof_q;
  assign o_resync        = resync_q;

endmodule

// File: tb/tb_s_axis_kernel_packer.sv
// Directed bench: single-pixel and four-pixel-per-beat packers.
module tb_s_axis_kernel_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Single pixel per beat instance
  logic        rstn_a, odd_a, tvalid_a, tuser_a, kready_a;
  logic [7:0]  tdata_a;
  logic        tready_a, kvalid_a, isodd_a, sof_a, resync_a;
  logic [0:63][7:0] kern_a;

  // Four pixels per beat instance
  logic        rstn_b, odd_b, tvalid_b, tuser_b, kready_b;
  logic [31:0] tdata_b;
  logic        tready_b, kvalid_b, isodd_b, sof_b, resync_b;
  logic [0:63][7:0] kern_b;

  s_axis_kernel_packer #(.DATA_WIDTH(8), .PIXELS_PER_BEAT(1), .KERNEL_SIZE(64)) dut_a (
    .i_clk(clk), .i_aresetn(rstn_a), .i_odd_kernel(odd_a),
    .i_axis_tdata(tdata_a), .i_axis_tvalid(tvalid_a), .i_axis_tuser(tuser_a),
    .o_axis_tready(tready_a), .o_image_kernel(kern_a), .o_kernel_valid(kvalid_a),
    .i_kernel_ready(kready_a), .o_kernel_is_odd(isodd_a), .o_kernel_sof(sof_a),
    .o_resync(resync_a)
  );

  s_axis_kernel_packer #(.DATA_WIDTH(8), .PIXELS_PER_BEAT(4), .KERNEL_SIZE(64)) dut_b (
    .i_clk(clk), .i_aresetn(rstn_b), .i_odd_kernel(odd_b),
    .i_axis_tdata(tdata_b), .i_axis_tvalid(tvalid_b), .i_axis_tuser(tuser_b),
    .o_axis_tready(tready_b), .o_image_kernel(kern_b), .o_kernel_valid(kvalid_b),
    .i_kernel_ready(kready_b), .o_kernel_is_odd(isodd_b), .o_kernel_sof(sof_b),
    .o_resync(resync_b)
  );

  int tready_drops = 0;
  int resync_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (resync_a) resync_pulses++;
  endtask

  // Offer one pixel to dut_a and wait (bounded) until it is accepted.
  task automatic send_a(input logic [7:0] d, input logic u, input logic o);
    logic took;
    took = 1'b0;
    tdata_a = d; tuser_a = u; odd_a = o; tvalid_a = 1'b1;
    for (int n = 0; n < 50 && !took; n++) begin
      took = tready_a;
      if (!took) tready_drops++;
      tick();
    end
    tvalid_a = 1'b0;
    if (!took) chk("send_a_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_b(input logic [31:0] d, input logic u, input logic o);
    logic took;
    took = 1'b0;
    tdata_b = d; tuser_b = u; odd_b = o; tvalid_b = 1'b1;
    for (int n = 0; n < 50 && !took; n++) begin
      took = tready_b;
      tick();
    end
    tvalid_b = 1'b0;
    if (!took) chk("send_b_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rstn_a = 1'b0; odd_a = 1'b0; tvalid_a = 1'b0; tuser_a = 1'b0; kready_a = 1'b1; tdata_a = '0;
    rstn_b = 1'b0; odd_b = 1'b0; tvalid_b = 1'b0; tuser_b = 1'b0; kready_b = 1'b1; tdata_b = '0;
    tick();
    tick();
    chk("rst_tready", tready_a, 0);
    chk("rst_valid", kvalid_a, 0);
    chk("rst_resync", resync_a, 0);
    chk("rst_kernel", kern_a[0], 0);
    rstn_a = 1'b1; rstn_b = 1'b1;
    tick();
    chk("post_rst_tready", tready_a, 1);

    // PPB=1: two back-to-back kernels, odd tag only on the first
    for (int p = 0; p < 64; p++) begin
      send_a(8'(p), p == 0, p == 0);
      if (p == 62) chk("k1_not_early", kvalid_a, 0);
    end
    chk("k1_valid", kvalid_a, 1);
    chk("k1_k0", kern_a[0], 0);
    chk("k1_k63", kern_a[63], 63);
    chk("k1_k37", kern_a[37], 37);
    chk("k1_sof", sof_a, 1);
    chk("k1_odd", isodd_a, 1);
    for (int p = 64; p < 128; p++) send_a(8'(p), 1'b0, 1'b0);
    chk("k2_valid", kvalid_a, 1);
    chk("k2_k0", kern_a[0], 64);
    chk("k2_k63", kern_a[63], 127);
    chk("k2_sof", sof_a, 0);
    chk("k2_odd", isodd_a, 0);
    chk("no_tready_drop", tready_drops, 0);
    tick();
    chk("k2_consumed", kvalid_a, 0);

    // Backpressure: two kernels with the consumer stalled
    kready_a = 1'b0;
    for (int p = 0; p < 128; p++) send_a(8'(p), p == 0, 1'b0);
    chk("bp_tready_low", tready_a, 0);
    chk("bp_valid", kvalid_a, 1);
    chk("bp_hold_k0", kern_a[0], 0);
    chk("bp_hold_k63", kern_a[63], 63);
    chk("bp_hold_sof", sof_a, 1);
    for (int n = 0; n < 5; n++) tick();
    chk("bp_still_low", tready_a, 0);
    chk("bp_still_k5", kern_a[5], 5);
    kready_a = 1'b1;
    tick();
    kready_a = 1'b0;
    chk("bp_k2_valid", kvalid_a, 1);
    chk("bp_k2_k0", kern_a[0], 64);
    chk("bp_k2_k63", kern_a[63], 127);
    chk("bp_k2_sof", sof_a, 0);
    chk("bp_tready_back", tready_a, 1);
    kready_a = 1'b1;
    tick();
    chk("bp_k2_consumed", kvalid_a, 0);

    // Resync: partial kernel of 10 beats cut by a tuser beat
    resync_pulses = 0;
    for (int p = 1; p <= 10; p++) send_a(8'(p), p == 1, 1'b0);
    chk("rs_quiet", resync_a, 0);
    send_a(8'hAA, 1'b1, 1'b0);
    chk("rs_pulse", resync_a, 1);
    for (int p = 0; p < 63; p++) send_a(8'(p), 1'b0, 1'b0);
    chk("rs_pulse_count", resync_pulses, 1);
    chk("rs_valid", kvalid_a, 1);
    chk("rs_k0", kern_a[0], 8'hAA);
    chk("rs_k1", kern_a[1], 0);
    chk("rs_k63", kern_a[63], 62);
    chk("rs_sof", sof_a, 1);
    tick();

    // Reset in the middle of a kernel
    for (int p = 0; p < 30; p++) send_a(8'h55, 1'b0, 1'b1);
    rstn_a = 1'b0;
    tick();
    chk("mr_tready", tready_a, 0);
    chk("mr_valid", kvalid_a, 0);
    chk("mr_resync", resync_a, 0);
    chk("mr_sof", sof_a, 0);
    chk("mr_odd", isodd_a, 0);
    chk("mr_k0", kern_a[0], 0);
    rstn_a = 1'b1;
    tick();
    for (int p = 0; p < 64; p++) send_a(8'(p * 3), 1'b0, 1'b0);
    chk("mr_new_valid", kvalid_a, 1);
    chk("mr_new_k0", kern_a[0], 0);
    chk("mr_new_k30", kern_a[30], 90);
    chk("mr_new_k63", kern_a[63], 189);
    chk("mr_new_odd", isodd_a, 0);

    // PPB=4: 16 beats per kernel, two kernels back to back
    for (int n = 0; n < 32; n++) begin
      chk("b_tready", tready_b, 1);
      send_b({8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)}, n == 0, 1'b0);
      if (n == 15) begin
        chk("b1_valid", kvalid_b, 1);
        chk("b1_k0", kern_b[0], 0);
        chk("b1_k17", kern_b[17], 17);
        chk("b1_k63", kern_b[63], 63);
        chk("b1_sof", sof_b, 1);
      end
      if (n == 14) chk("b1_not_early", kvalid_b, 0);
    end
    chk("b2_valid", kvalid_b, 1);
    chk("b2_k0", kern_b[0], 64);
    chk("b2_k63", kern_b[63], 127);
    chk("b2_sof", sof_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
